// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the accelerator datapath.
//   FFLAGS_WIDTH   width of the IEEE sticky flag vector {NV,DZ,OF,UF,NX}
//   ACC_ROB_DEPTH  default number of in-flight FPU operations
//   tag_t          FPU tag type for the default ROB depth
//   rob_entry_t    one reorder-buffer slot at the default data/address widths
package acc_pkg;

    localparam int FFLAGS_WIDTH       = 5;
    localparam int ACC_ROB_DEPTH      = 4;
    localparam int ACC_TAG_WIDTH      = $clog2(ACC_ROB_DEPTH);
    localparam int ACC_DATA_WIDTH     = 32;
    localparam int ACC_REG_ADDR_WIDTH = 5;

    typedef logic [ACC_TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic                          valid;
        logic                          done;
        logic                          wb;
        logic [ACC_REG_ADDR_WIDTH-1:0] waddr;
        logic [ACC_DATA_WIDTH-1:0]     data;
        logic [FFLAGS_WIDTH-1:0]       status;
    } rob_entry_t;

endpackage

// File: rtl/acc_rob_dispatch.sv
// acc_rob_dispatch: tag-based dispatch to the FPU with an in-order retire stage.
//   Each issued operation takes the ROB slot at tail and uses that index as its
//   FPU tag. Completions land in their slot in any order; the head slot retires
//   to the regfile write port (or just drops, for flag-only ops) once done.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_*                              request from the controller
//   fpu_valid_o/ready_i/payload_o/tag_o/flush_o   FPU input side
//   fpu_out_valid_i/ready_o/result_i/status_i/tag_i  FPU output side
//   wb_valid_o/ready_i/addr_o/data_o   regfile write port
//   fflags_o, fflags_clr_i             sticky exception flags and clear
//   flush_i                            discard everything in flight
//   count_o, busy_o                    occupancy
module acc_rob_dispatch
    import acc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REQ_WIDTH      = 128,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = ACC_ROB_DEPTH,
    parameter int TAG_WIDTH      = $clog2(DEPTH),
    parameter int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [REQ_WIDTH-1:0]      req_payload_i,
    input  logic [REG_ADDR_WIDTH-1:0] req_waddr_i,
    input  logic                      req_wb_i,
    output logic                      fpu_valid_o,
    input  logic                      fpu_ready_i,
    output logic [REQ_WIDTH-1:0]      fpu_payload_o,
    output logic [TAG_WIDTH-1:0]      fpu_tag_o,
    output logic                      fpu_flush_o,
    input  logic                      fpu_out_valid_i,
    output logic                      fpu_out_ready_o,
    input  logic [DATA_WIDTH-1:0]     fpu_result_i,
    input  logic [FFLAGS_WIDTH-1:0]   fpu_status_i,
    input  logic [TAG_WIDTH-1:0]      fpu_tag_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic [FFLAGS_WIDTH-1:0]   fflags_o,
    input  logic                      fflags_clr_i,
    input  logic                      flush_i,
    output logic [CNT_WIDTH-1:0]      count_o,
    output logic                      busy_o
);

    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0]          ent_done;
    logic [DEPTH-1:0]          ent_wb;
    logic [REG_ADDR_WIDTH-1:0] ent_waddr  [DEPTH];
    logic [DATA_WIDTH-1:0]     ent_data   [DEPTH];
    logic [FFLAGS_WIDTH-1:0]   ent_status [DEPTH];

    logic [TAG_WIDTH-1:0]      head;
    logic [TAG_WIDTH-1:0]      tail;
    logic [CNT_WIDTH-1:0]      count;
    logic [FFLAGS_WIDTH-1:0]   fflags;

    logic full;
    logic issue;
    logic comp;
    logic head_ready;
    logic pop;

    // Full is judged on registered count, so a slot freed by this cycle's
    // retire only becomes usable next cycle.
    assign full  = (count == CNT_WIDTH'(DEPTH));

    // Combinational outputs are gated by reset so that everything reads 0
    // while rst_ni is low, regardless of what the controller drives.
    assign req_ready_o     = rst_ni & fpu_ready_i & ~full & ~flush_i;
    assign fpu_valid_o     = rst_ni & req_valid_i & ~full & ~flush_i;
    assign fpu_payload_o   = rst_ni ? req_payload_i : '0;
    assign fpu_tag_o       = tail;
    assign fpu_flush_o     = rst_ni & flush_i;
    assign fpu_out_ready_o = rst_ni;

    assign issue = req_valid_i & req_ready_o;
    // Completions for empty slots, or arriving while flushing, are dropped.
    assign comp  = fpu_out_valid_i & ent_valid[fpu_tag_i] & ~flush_i;

    assign head_ready = ent_valid[head] & ent_done[head];
    assign pop        = head_ready & (~ent_wb[head] | wb_ready_i);

    assign wb_valid_o = head_ready & ent_wb[head];
    assign wb_addr_o  = ent_waddr[head];
    assign wb_data_o  = ent_data[head];

    assign fflags_o = fflags;
    assign count_o  = count;
    assign busy_o   = (count != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fflags    <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_wb    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_waddr[i]  <= '0;
                ent_data[i]   <= '0;
                ent_status[i] <= '0;
            end
        end else begin
            if (comp) begin
                ent_done[fpu_tag_i]   <= 1'b1;
                ent_data[fpu_tag_i]   <= fpu_result_i;
                ent_status[fpu_tag_i] <= fpu_status_i;
            end

            if (issue) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                ent_wb[tail]    <= req_wb_i;
                ent_waddr[tail] <= req_waddr_i;
                tail            <= tail + TAG_WIDTH'(1);
            end

            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + TAG_WIDTH'(1);
            end

            // Clear wipes older flags but never the status retiring right now.
            fflags <= (fflags_clr_i ? '0 : fflags) | (pop ? ent_status[head] : '0);

            case ({issue, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase

            // Flush overrides pointer/valid updates above; a retire in the
            // flush cycle has already taken effect on the write port and flags.
            if (flush_i) begin
                ent_valid <= '0;
                ent_done  <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_acc_rob_dispatch.sv
module tb_acc_rob_dispatch;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [127:0] req_payload_i;
    logic [4:0]   req_waddr_i;
    logic         req_wb_i;
    logic         fpu_valid_o;
    logic         fpu_ready_i;
    logic [127:0] fpu_payload_o;
    logic [1:0]   fpu_tag_o;
    logic         fpu_flush_o;
    logic         fpu_out_valid_i;
    logic         fpu_out_ready_o;
    logic [31:0]  fpu_result_i;
    logic [4:0]   fpu_status_i;
    logic [1:0]   fpu_tag_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [4:0]   wb_addr_o;
    logic [31:0]  wb_data_o;
    logic [4:0]   fflags_o;
    logic         fflags_clr_i;
    logic         flush_i;
    logic [2:0]   count_o;
    logic         busy_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    acc_rob_dispatch dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_payload_i   (req_payload_i),
        .req_waddr_i     (req_waddr_i),
        .req_wb_i        (req_wb_i),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_payload_o   (fpu_payload_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_flush_o     (fpu_flush_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_tag_i       (fpu_tag_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o),
        .fflags_o        (fflags_o),
        .fflags_clr_i    (fflags_clr_i),
        .flush_i         (flush_i),
        .count_o         (count_o),
        .busy_o          (busy_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: state updates at posedge, next stimulus at negedge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic [4:0] waddr, input logic wb);
        req_valid_i   = 1'b1;
        req_waddr_i   = waddr;
        req_wb_i      = wb;
        req_payload_i = {96'h0, 27'h0, waddr};
    endtask

    task automatic complete(input logic [1:0] tag, input logic [31:0] data, input logic [4:0] st);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = tag;
        fpu_result_i    = data;
        fpu_status_i    = st;
    endtask

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = 1'b1;
        req_payload_i   = 128'hDEAD_BEEF;
        req_waddr_i     = 5'd0;
        req_wb_i        = 1'b1;
        fpu_ready_i     = 1'b1;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        fpu_tag_i       = '0;
        wb_ready_i      = 1'b1;
        fflags_clr_i    = 1'b0;
        flush_i         = 1'b1;
        @(negedge clk_i);
        settle();
        // Reset state with active inputs.
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_fpu_valid", fpu_valid_o, 0);
        chk("rst_fpu_payload", fpu_payload_o, 0);
        chk("rst_fpu_flush", fpu_flush_o, 0);
        chk("rst_out_ready", fpu_out_ready_o, 0);
        chk("rst_count", count_o, 0);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        settle();
        chk("post_rst_out_ready", fpu_out_ready_o, 1);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_fflags", fflags_o, 0);

        // ---- in-order ----
        issue(5'd3, 1'b1);
        settle();
        chk("io_fpu_valid", fpu_valid_o, 1);
        chk("io_req_ready", req_ready_o, 1);
        chk("io_tag_a", fpu_tag_o, 0);
        chk("io_payload", fpu_payload_o, 128'h3);
        tick();
        issue(5'd4, 1'b1);
        settle();
        chk("io_tag_b", fpu_tag_o, 1);
        tick();
        req_valid_i = 1'b0;
        complete(2'd0, 32'h3F80_0000, 5'b0);
        settle();
        chk("io_count2", count_o, 2);
        chk("io_no_wb_yet", wb_valid_o, 0);
        tick();
        complete(2'd1, 32'h4000_0000, 5'b0);
        settle();
        chk("io_wb0_valid", wb_valid_o, 1);
        chk("io_wb0_addr", wb_addr_o, 3);
        chk("io_wb0_data", wb_data_o, 32'h3F80_0000);
        tick();
        fpu_out_valid_i = 1'b0;
        settle();
        chk("io_wb1_valid", wb_valid_o, 1);
        chk("io_wb1_addr", wb_addr_o, 4);
        chk("io_wb1_data", wb_data_o, 32'h4000_0000);
        tick();
        settle();
        chk("io_wb_done", wb_valid_o, 0);
        chk("io_count0", count_o, 0);

        // ---- out-of-order ----
        do_reset();
        issue(5'd10, 1'b1); settle(); chk("ooo_tag0", fpu_tag_o, 0); tick();
        issue(5'd11, 1'b1); settle(); chk("ooo_tag1", fpu_tag_o, 1); tick();
        issue(5'd12, 1'b1); settle(); chk("ooo_tag2", fpu_tag_o, 2); tick();
        req_valid_i = 1'b0;
        complete(2'd2, 32'hC, 5'b0);
        tick();
        complete(2'd0, 32'hA, 5'b00001);
        settle();
        chk("ooo_tag2_held", wb_valid_o, 0);
        tick();
        complete(2'd1, 32'hB, 5'b0);
        settle();
        chk("ooo_wb0_addr", wb_addr_o, 10);
        chk("ooo_wb0_data", wb_data_o, 32'hA);
        chk("ooo_flags_before", fflags_o, 0);
        tick();
        fpu_out_valid_i = 1'b0;
        settle();
        chk("ooo_flags_after", fflags_o, 5'b00001);
        chk("ooo_wb1_valid", wb_valid_o, 1);
        chk("ooo_wb1_addr", wb_addr_o, 11);
        chk("ooo_wb1_data", wb_data_o, 32'hB);
        tick();
        settle();
        chk("ooo_wb2_addr", wb_addr_o, 12);
        chk("ooo_wb2_data", wb_data_o, 32'hC);
        tick();
        settle();
        chk("ooo_empty", count_o, 0);
        chk("ooo_flags_sticky", fflags_o, 5'b00001);

        // ---- full / backpressure ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(5'(i + 1), 1'b1);
            settle();
            chk("full_tag", fpu_tag_o, 128'(i));
            tick();
        end
        settle();
        chk("full_req_ready", req_ready_o, 0);
        chk("full_fpu_valid", fpu_valid_o, 0);
        chk("full_count", count_o, 4);
        req_valid_i = 1'b0;
        wb_ready_i  = 1'b0;
        complete(2'd0, 32'h11, 5'b0);
        tick();
        fpu_out_valid_i = 1'b0;
        settle();
        chk("bp_wb_valid", wb_valid_o, 1);
        chk("bp_count", count_o, 4);
        tick();
        settle();
        chk("bp_wb_held", wb_valid_o, 1);
        chk("bp_count_held", count_o, 4);
        chk("bp_wb_data", wb_data_o, 32'h11);
        wb_ready_i = 1'b1;
        settle();
        chk("bp_retire_cycle_ready", req_ready_o, 0);
        tick();
        settle();
        chk("bp_count_pop", count_o, 3);
        chk("bp_ready_next", req_ready_o, 1);
        chk("bp_next_head", wb_valid_o, 0);

        // ---- no writeback ----
        do_reset();
        issue(5'd7, 1'b0);
        tick();
        req_valid_i = 1'b0;
        complete(2'd0, 32'h99, 5'b01000);
        tick();
        fpu_out_valid_i = 1'b0;
        settle();
        chk("nowb_wb_valid", wb_valid_o, 0);
        chk("nowb_count_pre", count_o, 1);
        tick();
        settle();
        chk("nowb_count_post", count_o, 0);
        chk("nowb_fflags", fflags_o, 5'b01000);
        chk("nowb_wb_after", wb_valid_o, 0);

        // ---- flush ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(5'(20 + i), 1'b1);
            tick();
        end
        flush_i = 1'b1;
        settle();
        chk("fl_flush_same", fpu_flush_o, 1);
        chk("fl_issue_blocked", fpu_valid_o, 0);
        chk("fl_ready_blocked", req_ready_o, 0);
        tick();
        settle();
        chk("fl_count0", count_o, 0);
        chk("fl_held_blocked", fpu_valid_o, 0);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        complete(2'd1, 32'h55, 5'b10000);
        tick();
        fpu_out_valid_i = 1'b0;
        settle();
        chk("fl_late_no_wb", wb_valid_o, 0);
        chk("fl_late_count", count_o, 0);
        issue(5'd5, 1'b1);
        settle();
        chk("fl_next_tag", fpu_tag_o, 0);
        tick();
        req_valid_i = 1'b0;
        tick();
        settle();
        chk("fl_late_no_wb2", wb_valid_o, 0);
        chk("fl_fflags_kept", fflags_o, 0);

        // ---- reset mid-operation, then clear+retire ----
        do_reset();
        issue(5'd1, 1'b0);
        tick();
        req_valid_i = 1'b0;
        complete(2'd0, 32'h1, 5'b00001);
        tick();
        fpu_out_valid_i = 1'b0;
        issue(5'd9, 1'b1);
        tick();
        settle();
        chk("mid_fflags_set", fflags_o, 5'b00001);
        chk("mid_count", count_o, 1);
        rst_ni  = 1'b0;
        flush_i = 1'b1;
        settle();
        chk("mid_rst_fflags", fflags_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_fpu_valid", fpu_valid_o, 0);
        chk("mid_rst_flush", fpu_flush_o, 0);
        chk("mid_rst_tag", fpu_tag_o, 0);
        chk("mid_rst_wb", {wb_valid_o, wb_addr_o, wb_data_o}, 0);
        tick();
        rst_ni      = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        settle();
        chk("mid_post_count", count_o, 0);
        issue(5'd2, 1'b0);
        tick();
        req_valid_i = 1'b0;
        complete(2'd0, 32'h2, 5'b00001);
        tick();
        fpu_out_valid_i = 1'b0;
        issue(5'd6, 1'b1);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("clr_fflags_pre", fflags_o, 5'b00001);
        complete(2'd1, 32'h77, 5'b00100);
        tick();
        fpu_out_valid_i = 1'b0;
        fflags_clr_i    = 1'b1;
        settle();
        chk("clr_wb_addr", wb_addr_o, 6);
        chk("clr_wb_data", wb_data_o, 32'h77);
        tick();
        fflags_clr_i = 1'b0;
        settle();
        chk("clr_fflags_post", fflags_o, 5'b00100);
        chk("clr_count", count_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
